// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle Moore control FSM for a MIPS subset with a memory-ready timeout.
// Optional feature: define MC_ILLEGAL_TRAP_EN to send unlisted opcodes to ERROR (default: NOP).
module mc_control_fsm #(
    parameter int ALUOP_W = 3,
    parameter int TMO_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               is_jal,
    output logic               error,
    output logic [3:0]         state_o
);
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC_R = 4'd7,
        S_EXEC_I = 4'd8,  S_ALU_WB = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
        S_ERROR  = 4'd12
    } state_e;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;
    localparam logic [5:0] OPC_LUI   = 6'b001111;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    localparam logic [ALUOP_W-1:0] OP_ADD   = ALUOP_W'(3'd0);
    localparam logic [ALUOP_W-1:0] OP_SUB   = ALUOP_W'(3'd1);
    localparam logic [ALUOP_W-1:0] OP_FUNCT = ALUOP_W'(3'd2);
    localparam logic [ALUOP_W-1:0] OP_SLT   = ALUOP_W'(3'd3);
    localparam logic [ALUOP_W-1:0] OP_AND   = ALUOP_W'(3'd4);
    localparam logic [ALUOP_W-1:0] OP_OR    = ALUOP_W'(3'd5);
    localparam logic [ALUOP_W-1:0] OP_XOR   = ALUOP_W'(3'd6);
    localparam logic [ALUOP_W-1:0] OP_LUI   = ALUOP_W'(3'd7);

    localparam logic [TMO_W-1:0] CNT_MAX = {TMO_W{1'b1}};

    state_e           state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             rtype_q, rtype_d;
    logic             error_q, error_d;
    logic             wait_st_s;
    logic             timeout_s;

    // Timeout fires in the cycle the counter sits at its terminal value with memory still busy.
    always_comb begin
        wait_st_s = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        timeout_s = wait_st_s && !mem_ready && (cnt_q == CNT_MAX);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready)      state_d = S_DECODE;
                else if (timeout_s) state_d = S_ERROR;
                else                state_d = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OPC_RTYPE:                   state_d = S_EXEC_R;
                    OPC_LW, OPC_SW:              state_d = S_MEMADR;
                    OPC_ADDI, OPC_SLTI, OPC_ANDI,
                    OPC_ORI, OPC_XORI, OPC_LUI:  state_d = S_EXEC_I;
                    OPC_BEQ, OPC_BNE:            state_d = S_BRANCH;
                    OPC_J, OPC_JAL:              state_d = S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:                     state_d = S_ERROR;
`else
                    default:                     state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                if (opcode == OPC_SW) state_d = S_MEMWR;
                else                  state_d = S_MEMRD;
            end
            S_MEMRD: begin
                if (mem_ready)      state_d = S_MEMWB;
                else if (timeout_s) state_d = S_ERROR;
                else                state_d = S_MEMRD;
            end
            S_MEMWR: begin
                if (mem_ready)      state_d = S_FETCH;
                else if (timeout_s) state_d = S_ERROR;
                else                state_d = S_MEMWR;
            end
            S_EXEC_R, S_EXEC_I:                state_d = S_ALU_WB;
            S_MEMWB, S_ALU_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_ERROR:                           state_d = S_ERROR;
            default:                           state_d = S_ERROR;
        endcase
    end

    // Wait counter restarts on every state change; the latched R-type bit selects rd in ALU_WB.
    always_comb begin
        cnt_d   = cnt_q;
        rtype_d = rtype_q;
        error_d = error_q;
        if (state_d != state_q)          cnt_d = '0;
        else if (wait_st_s && !mem_ready) cnt_d = cnt_q + TMO_W'(1'b1);
        else                             cnt_d = cnt_q;
        if (state_q == S_EXEC_R)      rtype_d = 1'b1;
        else if (state_q == S_EXEC_I) rtype_d = 1'b0;
        else                          rtype_d = rtype_q;
        if (state_d == S_ERROR) error_d = 1'b1;
        else                    error_d = error_q;
    end

    // State, counter, and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rtype_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rtype_q <= rtype_d;
            error_q <= error_d;
        end
    end

    // Moore output decode; ir_write/pc_write additionally qualified by mem_ready or zero.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = OP_ADD;
        reg_dst    = 2'b00;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        is_jal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = OP_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    OPC_SLTI: alu_op = OP_SLT;
                    OPC_ANDI: alu_op = OP_AND;
                    OPC_ORI:  alu_op = OP_OR;
                    OPC_XORI: alu_op = OP_XOR;
                    OPC_LUI:  alu_op = OP_LUI;
                    default:  alu_op = OP_ADD;
                endcase
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                if (rtype_q) reg_dst = 2'b01;
                else         reg_dst = 2'b00;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = OP_SUB;
                pc_src    = 2'b01;
                if (opcode == OPC_BEQ)      pc_write = zero;
                else if (opcode == OPC_BNE) pc_write = ~zero;
                else                        pc_write = 1'b0;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                if (opcode == OPC_JAL) begin
                    reg_write = 1'b1;
                    reg_dst   = 2'b10;
                    is_jal    = 1'b1;
                end else begin
                    is_jal    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign error   = error_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: stimulus pushes per-cycle expected state/controls, a monitor compares.
module tb_mc_control_fsm;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero, mem_ready;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0] pc_src, alu_src_b, reg_dst;
    logic       alu_src_a, mem_to_reg, reg_write, is_jal, error;
    logic [2:0] alu_op;
    logic [3:0] state_o;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .is_jal(is_jal), .error(error), .state_o(state_o)
    );

    always #5 clk = ~clk;

    localparam int IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5, MEMWR = 6,
                   EXEC_R = 7, EXEC_I = 8, ALU_WB = 9, BRANCH = 10, JUMP = 11, ERROR = 12;

    localparam logic [5:0] O_R = 6'b000000, O_J = 6'b000010, O_JAL = 6'b000011, O_BEQ = 6'b000100,
                           O_BNE = 6'b000101, O_LW = 6'b100011, O_SW = 6'b101011, O_ILL = 6'b111111;

    function automatic logic [18:0] mk(input int mr, input int mw, input int iod, input int irw,
                                       input int pcw, input int pcs, input int a, input int b,
                                       input int op, input int rd, input int m2r, input int rw,
                                       input int jal, input int err);
        return {mr[0], mw[0], iod[0], irw[0], pcw[0], pcs[1:0], a[0], b[1:0], op[2:0],
                rd[1:0], m2r[0], rw[0], jal[0], err[0]};
    endfunction

    localparam logic [18:0] C_IDLE       = mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,0);
    localparam logic [18:0] C_FETCH_WAIT = mk(1,0,0,0,0, 0,0,1,0, 0,0,0,0,0);
    localparam logic [18:0] C_FETCH_RDY  = mk(1,0,0,1,1, 0,0,1,0, 0,0,0,0,0);
    localparam logic [18:0] C_DECODE     = mk(0,0,0,0,0, 0,0,3,0, 0,0,0,0,0);
    localparam logic [18:0] C_MEMADR     = mk(0,0,0,0,0, 0,1,2,0, 0,0,0,0,0);
    localparam logic [18:0] C_MEMRD      = mk(1,0,1,0,0, 0,0,0,0, 0,0,0,0,0);
    localparam logic [18:0] C_MEMWB      = mk(0,0,0,0,0, 0,0,0,0, 0,1,1,0,0);
    localparam logic [18:0] C_MEMWR      = mk(0,1,1,0,0, 0,0,0,0, 0,0,0,0,0);
    localparam logic [18:0] C_EXEC_R     = mk(0,0,0,0,0, 0,1,0,2, 0,0,0,0,0);
    localparam logic [18:0] C_ALUWB_R    = mk(0,0,0,0,0, 0,0,0,0, 1,0,1,0,0);
    localparam logic [18:0] C_ALUWB_I    = mk(0,0,0,0,0, 0,0,0,0, 0,0,1,0,0);
    localparam logic [18:0] C_BR_T       = mk(0,0,0,0,1, 1,1,0,1, 0,0,0,0,0);
    localparam logic [18:0] C_BR_N       = mk(0,0,0,0,0, 1,1,0,1, 0,0,0,0,0);
    localparam logic [18:0] C_J          = mk(0,0,0,0,1, 2,0,0,0, 0,0,0,0,0);
    localparam logic [18:0] C_JAL        = mk(0,0,0,0,1, 2,0,0,0, 2,0,1,1,0);
    localparam logic [18:0] C_ERR        = mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,1);

    typedef struct {
        logic [3:0]  st;
        logic [18:0] ctl;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    string       cur_tag;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [18:0] act_ctl;

    assign act_ctl = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
                      alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, is_jal, error};

    // Monitor: one expected entry per clock cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_tests++;
            if (state_o !== mon_e.st || act_ctl !== mon_e.ctl) begin
                n_fail++;
                $display("FAIL %s: got state=%0d ctl=%05h, expected state=%0d ctl=%05h",
                         mon_e.tag, state_o, act_ctl, mon_e.st, mon_e.ctl);
            end
        end
    end

    task automatic cyc(input logic [5:0] op, input logic z, input logic rdy,
                       input int est, input logic [18:0] ectl);
        exp_t e;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        e.st  = est[3:0];
        e.ctl = ectl;
        e.tag = cur_tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [5:0] op);
        cyc(op, 1'b0, 1'b1, FETCH, C_FETCH_RDY);
        cyc(op, 1'b0, 1'b1, DECODE, C_DECODE);
    endtask

    logic [5:0] i_opc [6] = '{6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b001111};
    int         i_alu [6] = '{0, 3, 4, 5, 6, 7};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        cur_tag = "reset";
        cyc(O_R, 1'b0, 1'b1, IDLE, C_IDLE);
        cyc(O_R, 1'b0, 1'b1, IDLE, C_IDLE);
        rst_n = 1'b1;

        cur_tag = "rtype";
        cyc(O_R, 1'b0, 1'b1, IDLE, C_IDLE);
        fetch_decode(O_R);
        cyc(O_R, 1'b0, 1'b1, EXEC_R, C_EXEC_R);
        cyc(O_R, 1'b0, 1'b1, ALU_WB, C_ALUWB_R);

        cur_tag = "lw_wait";
        fetch_decode(O_LW);
        cyc(O_LW, 1'b0, 1'b1, MEMADR, C_MEMADR);
        for (int k = 0; k < 3; k++) cyc(O_LW, 1'b0, 1'b0, MEMRD, C_MEMRD);
        cyc(O_LW, 1'b0, 1'b1, MEMRD, C_MEMRD);
        cyc(O_LW, 1'b0, 1'b1, MEMWB, C_MEMWB);

        cur_tag = "sw_fetchwait";
        cyc(O_SW, 1'b0, 1'b0, FETCH, C_FETCH_WAIT);
        cyc(O_SW, 1'b0, 1'b0, FETCH, C_FETCH_WAIT);
        fetch_decode(O_SW);
        cyc(O_SW, 1'b0, 1'b1, MEMADR, C_MEMADR);
        cyc(O_SW, 1'b0, 1'b1, MEMWR, C_MEMWR);

        cur_tag = "beq_z1";
        fetch_decode(O_BEQ); cyc(O_BEQ, 1'b1, 1'b1, BRANCH, C_BR_T);
        cur_tag = "bne_z1";
        fetch_decode(O_BNE); cyc(O_BNE, 1'b1, 1'b1, BRANCH, C_BR_N);
        cur_tag = "beq_z0";
        fetch_decode(O_BEQ); cyc(O_BEQ, 1'b0, 1'b1, BRANCH, C_BR_N);
        cur_tag = "bne_z0";
        fetch_decode(O_BNE); cyc(O_BNE, 1'b0, 1'b1, BRANCH, C_BR_T);

        cur_tag = "jal";
        fetch_decode(O_JAL); cyc(O_JAL, 1'b0, 1'b1, JUMP, C_JAL);
        cur_tag = "j";
        fetch_decode(O_J); cyc(O_J, 1'b0, 1'b1, JUMP, C_J);

        cur_tag = "itype";
        for (int k = 0; k < 6; k++) begin
            fetch_decode(i_opc[k]);
            cyc(i_opc[k], 1'b0, 1'b1, EXEC_I, mk(0,0,0,0,0, 0,1,2,i_alu[k], 0,0,0,0,0));
            cyc(i_opc[k], 1'b0, 1'b1, ALU_WB, C_ALUWB_I);
        end

        cur_tag = "tmo_edge_ready_wins";
        for (int k = 0; k < 15; k++) cyc(O_R, 1'b0, 1'b0, FETCH, C_FETCH_WAIT);
        cyc(O_R, 1'b0, 1'b1, FETCH, C_FETCH_RDY);
        cyc(O_R, 1'b0, 1'b1, DECODE, C_DECODE);
        cyc(O_R, 1'b0, 1'b1, EXEC_R, C_EXEC_R);
        cyc(O_R, 1'b0, 1'b1, ALU_WB, C_ALUWB_R);

        cur_tag = "illegal_opcode";
        fetch_decode(O_ILL);
`ifdef MC_ILLEGAL_TRAP_EN
        cyc(O_ILL, 1'b0, 1'b1, ERROR, C_ERR);
        cyc(O_ILL, 1'b0, 1'b1, ERROR, C_ERR);
        rst_n = 1'b0;
        cyc(O_SW, 1'b0, 1'b1, IDLE, C_IDLE);
        rst_n = 1'b1;
        cyc(O_SW, 1'b0, 1'b1, IDLE, C_IDLE);
`endif

        cur_tag = "reset_mid_memwr";
        fetch_decode(O_SW);
        cyc(O_SW, 1'b0, 1'b1, MEMADR, C_MEMADR);
        cyc(O_SW, 1'b0, 1'b0, MEMWR, C_MEMWR);
        cyc(O_SW, 1'b0, 1'b0, MEMWR, C_MEMWR);
        rst_n = 1'b0;
        cyc(O_SW, 1'b0, 1'b0, IDLE, C_IDLE);
        cyc(O_SW, 1'b0, 1'b0, IDLE, C_IDLE);
        rst_n = 1'b1;
        cyc(O_R, 1'b0, 1'b0, IDLE, C_IDLE);

        cur_tag = "fetch_timeout";
        for (int k = 0; k < 16; k++) cyc(O_R, 1'b0, 1'b0, FETCH, C_FETCH_WAIT);
        for (int k = 0; k < 3; k++) cyc(O_R, 1'b0, 1'b1, ERROR, C_ERR);
        rst_n = 1'b0;
        cur_tag = "reset_clears_error";
        cyc(O_R, 1'b0, 1'b1, IDLE, C_IDLE);
        rst_n = 1'b1;
        cyc(O_R, 1'b0, 1'b1, IDLE, C_IDLE);
        cyc(O_R, 1'b0, 1'b1, FETCH, C_FETCH_RDY);

        repeat (2) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
